// File: rtl/carryskip_sub_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : carryskip_sub_pipe                                           |
// | Description : Pipelined a - b - bin subtractor, one 4-bit carry-skip slice |
// |               per stage, valid/ready handshakes on both sides.             |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module carryskip_sub_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / BLOCK;

  logic [STAGES-1:0] w_v;
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_load;
  logic              r_ovf;
  logic              w_ovf_next;

  assign in_ready = ~w_v[0] | w_adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be consumed from this slice upwards, and diff width so far.
    localparam int IW = WIDTH - k * BLOCK;
    localparam int DW = (k + 1) * BLOCK;

    logic [IW-1:0]    w_a_in;
    logic [IW-1:0]    w_nb_in;
    logic             w_cin;
    logic [BLOCK-1:0] w_p;
    logic [BLOCK-1:0] w_g;
    logic [BLOCK-1:0] w_sum;
    logic [BLOCK:0]   w_rc;
    logic             w_cout;
    logic [DW-1:0]    w_dnext;

    logic             r_v;
    logic [DW-1:0]    r_diff;
    logic             r_brw;

    if (k == 0) begin : g_src_port
      assign w_a_in  = a;
      assign w_nb_in = ~b;
      assign w_cin   = ~bin;
      assign w_dnext = w_sum;
      assign w_load[k] = in_valid & in_ready;
    end else begin : g_src_stage
      assign w_a_in  = g_stage[k-1].g_ops.r_a;
      assign w_nb_in = g_stage[k-1].g_ops.r_nb;
      assign w_cin   = ~g_stage[k-1].r_brw;
      assign w_dnext = {w_sum, g_stage[k-1].r_diff};
      assign w_load[k] = w_adv[k-1];
    end

    if (k == STAGES - 1) begin : g_adv_last
      assign w_adv[k] = r_v & out_ready;
    end else begin : g_adv_mid
      assign w_adv[k] = r_v & (~w_v[k+1] | w_adv[k+1]);
    end

    assign w_v[k] = r_v;
    assign w_g    = w_a_in[BLOCK-1:0] & w_nb_in[BLOCK-1:0];
    assign w_p    = w_a_in[BLOCK-1:0] ^ w_nb_in[BLOCK-1:0];

    always_comb begin
      w_rc[0] = w_cin;
      for (int i = 0; i < BLOCK; i++) begin
        w_rc[i+1] = w_g[i] | (w_p[i] & w_rc[i]);
      end
    end

    assign w_sum = w_p ^ w_rc[BLOCK-1:0];
    // A fully propagating slice passes its carry-in straight through.
    assign w_cout = (&w_p) ? w_cin : w_rc[BLOCK];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v    <= 1'b0;
        r_diff <= '0;
        r_brw  <= 1'b0;
      end else begin
        r_v <= w_load[k] | (r_v & ~w_adv[k]);
        if (w_load[k]) begin
          r_diff <= w_dnext;
          r_brw  <= ~w_cout;
        end
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [IW-BLOCK-1:0] r_a;
      logic [IW-BLOCK-1:0] r_nb;

      always_ff @(posedge clk) begin
        if (w_load[k]) begin
          r_a  <= w_a_in[IW-1:BLOCK];
          r_nb <= w_nb_in[IW-1:BLOCK];
        end
      end
    end
  end

  // Operand MSBs reach the last slice as the top bits of its operand inputs.
  assign w_ovf_next = (g_stage[STAGES-1].w_a_in[BLOCK-1] != ~g_stage[STAGES-1].w_nb_in[BLOCK-1]) &
                      (g_stage[STAGES-1].w_sum[BLOCK-1]  !=  g_stage[STAGES-1].w_a_in[BLOCK-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_load[STAGES-1]) begin
      r_ovf <= w_ovf_next;
    end
  end

  assign out_valid = w_v[STAGES-1];
  assign diff      = g_stage[STAGES-1].r_diff;
  assign bout      = g_stage[STAGES-1].r_brw;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire
